ritc_phase_shift_responder: RTL and testbench

- Responder end of the RITC phase-control bus.
- Accepts single-cycle PSEN/PSINCDEC requests from the phase scanner (phase_control_out) and issues them to the MMCM dynamic phase-shift port.
- Tracks the signed accumulated phase position and enforces step limits.
- Returns a one-cycle PSDONE plus status bits on the scanner's phase_control_in bus.

---
 rtl/ritc_phase_shift_responder.sv | 152 +++++++++++++++
 tb/tb_ritc_phase_shift_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_phase_shift_responder.sv
// Responder end of the RITC phase-control bus: turns scanner PSEN requests into
// MMCM dynamic phase-shift steps, tracks the signed phase position and reports status.
module ritc_phase_shift_responder #(
   parameter int MAX_STEPS = 1120,
   parameter int TIMEOUT   = 255,
   parameter int PHASE_W   = 12
) (
   input  logic               user_clk_i,
   input  logic               rst_i,
   input  logic [7:0]         phase_control_out,
   output logic [7:0]         phase_control_in,
   output logic               mmcm_psen_o,
   output logic               mmcm_psincdec_o,
   input  logic               mmcm_psdone_i,
   input  logic               mmcm_locked_i,
   output logic [PHASE_W-1:0] phase_pos_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic signed [PHASE_W-1:0] POS_MAX = PHASE_W'(MAX_STEPS);
   localparam logic signed [PHASE_W-1:0] POS_MIN = PHASE_W'(-MAX_STEPS);
   localparam logic signed [PHASE_W-1:0] POS_ONE = PHASE_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                    state_r, state_nx_s;
   logic                      lk_meta_r, lk_sync_r, lk_prev_r;
   logic                      dir_r, dir_nx_s;
   logic [CNT_W-1:0]          cnt_r, cnt_nx_s;
   logic signed [PHASE_W-1:0] pos_r, pos_nx_s;
   logic                      tmo_r, tmo_nx_s;
   logic                      rej_r, rej_nx_s;
   logic                      ovr_r, ovr_nx_s;
   logic                      psen_r, psincdec_r, psdone_r, busy_r;
   logic                      req_s, inc_s, accept_s;
   logic                      at_max_s, at_min_s, lk_fall_s;

   assign req_s     = phase_control_out[0];
   assign inc_s     = phase_control_out[1];
   assign at_max_s  = (pos_r == POS_MAX);
   assign at_min_s  = (pos_r == POS_MIN);
   assign lk_fall_s = lk_prev_r & ~lk_sync_r;
   assign accept_s  = lk_sync_r & ~(inc_s & at_max_s) & ~(~inc_s & at_min_s);

   // Double-flop synchroniser for MMCM LOCKED plus a delayed copy for edge detection
   always_ff @(posedge user_clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_meta_r <= 1'b0;
         lk_sync_r <= 1'b0;
         lk_prev_r <= 1'b0;
      end else begin
         lk_meta_r <= mmcm_locked_i;
         lk_sync_r <= lk_meta_r;
         lk_prev_r <= lk_sync_r;
      end
   end

   // Next-state and datapath update for the request FSM
   always_comb begin
      state_nx_s = state_r;
      dir_nx_s   = dir_r;
      cnt_nx_s   = cnt_r;
      pos_nx_s   = pos_r;
      tmo_nx_s   = tmo_r;
      rej_nx_s   = rej_r;
      ovr_nx_s   = ovr_r | req_s;
      case (state_r)
         ST_IDLE: begin
            ovr_nx_s = ovr_r;
            if (req_s && accept_s) begin
               dir_nx_s   = inc_s;
               tmo_nx_s   = 1'b0;
               rej_nx_s   = 1'b0;
               ovr_nx_s   = 1'b0;
               state_nx_s = ST_ISSUE;
            end else if (req_s) begin
               rej_nx_s   = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_nx_s   = CNT_W'(TIMEOUT);
            state_nx_s = ST_WAIT;
         end
         ST_WAIT: begin
            // Lost lock aborts first; a PSDONE arriving with the last count still wins
            if (!lk_sync_r) begin
               tmo_nx_s   = 1'b1;
               state_nx_s = ST_DONE;
            end else if (mmcm_psdone_i) begin
               pos_nx_s   = dir_r ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
               state_nx_s = ST_DONE;
            end else if (cnt_r <= CNT_W'(1)) begin
               cnt_nx_s   = {CNT_W{1'b0}};
               tmo_nx_s   = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               cnt_nx_s   = cnt_r - CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // FSM state, phase position, sticky flags and registered bus outputs
   always_ff @(posedge user_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         dir_r      <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
         pos_r      <= {PHASE_W{1'b0}};
         tmo_r      <= 1'b0;
         rej_r      <= 1'b0;
         ovr_r      <= 1'b0;
         psen_r     <= 1'b0;
         psincdec_r <= 1'b0;
         psdone_r   <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         dir_r      <= dir_nx_s;
         cnt_r      <= cnt_nx_s;
         pos_r      <= lk_fall_s ? {PHASE_W{1'b0}} : pos_nx_s;
         tmo_r      <= tmo_nx_s;
         rej_r      <= rej_nx_s;
         ovr_r      <= ovr_nx_s;
         psen_r     <= (state_r == ST_ISSUE);
         psincdec_r <= (state_r == ST_ISSUE) ? dir_r : psincdec_r;
         psdone_r   <= (state_r == ST_DONE);
         busy_r     <= (state_r != ST_IDLE);
      end
   end

   assign mmcm_psen_o      = psen_r;
   assign mmcm_psincdec_o  = psincdec_r;
   assign phase_pos_o      = pos_r;
   assign phase_control_in = {ovr_r, lk_sync_r, rej_r, tmo_r,
                              at_min_s, at_max_s, busy_r, psdone_r};

endmodule

// File: tb/tb_ritc_phase_shift_responder.sv
// Scoreboard bench for ritc_phase_shift_responder: expected PSDONE status is queued per
// request and compared when the responder returns PSDONE; MMCM modelled behaviourally.
module tb_ritc_phase_shift_responder;

   localparam int MAXS    = 1120;
   localparam int TIMEOUT = 255;

   typedef struct {
      int pos;
      bit tmo;
      bit rej;
      bit ovr;
   } exp_t;

   logic        user_clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [7:0]  phase_control_out = 8'd0;
   logic [7:0]  phase_control_in;
   logic        mmcm_psen_o, mmcm_psincdec_o;
   logic        mmcm_psdone_i = 1'b0;
   logic        mmcm_locked_i = 1'b1;
   logic [11:0] phase_pos_o;

   int   n_checks = 0, n_fail = 0;
   int   cyc = 0;
   int   psen_cnt = 0, psen_cyc = 0, psdone_cnt = 0, psdone_cyc = 0, done_in_cyc = 0;
   bit   psen_dir = 1'b0;
   int   drv_cyc = 0;
   int   mdl_delay = 1, mdl_cnt = 0;
   int   m_pos = 0;
   bit   m_tmo = 1'b0, m_rej = 1'b0, m_ovr = 1'b0, m_locked = 1'b1;
   exp_t sb_q[$];

   ritc_phase_shift_responder dut (
      .user_clk_i        (user_clk_i),
      .rst_i             (rst_i),
      .phase_control_out (phase_control_out),
      .phase_control_in  (phase_control_in),
      .mmcm_psen_o       (mmcm_psen_o),
      .mmcm_psincdec_o   (mmcm_psincdec_o),
      .mmcm_psdone_i     (mmcm_psdone_i),
      .mmcm_locked_i     (mmcm_locked_i),
      .phase_pos_o       (phase_pos_o)
   );

   always #5 user_clk_i = ~user_clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge user_clk_i);
         #1;
      end
   endtask

   // Monitor: cycle count, MMCM/PSDONE events, scoreboard compare on PSDONE
   initial begin
      exp_t e;
      forever begin
         @(posedge user_clk_i);
         cyc++;
         if (mmcm_psdone_i) done_in_cyc = cyc;
         #1;
         if (mmcm_psen_o) begin
            psen_cnt++;
            psen_cyc = cyc;
            psen_dir = mmcm_psincdec_o;
         end
         if (phase_control_in[0]) begin
            psdone_cnt++;
            psdone_cyc = cyc;
            if (sb_q.size() == 0) begin
               check("spurious_psdone", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("pos", int'($signed(phase_pos_o)), e.pos);
               check("timeout_err", int'(phase_control_in[4]), int'(e.tmo));
               check("reject_err", int'(phase_control_in[5]), int'(e.rej));
               check("overrun_err", int'(phase_control_in[7]), int'(e.ovr));
               check("at_max", int'(phase_control_in[2]), int'(e.pos == MAXS));
               check("at_min", int'(phase_control_in[3]), int'(e.pos == -MAXS));
            end
         end
      end
   end

   // MMCM model: PSDONE mdl_delay cycles after PSEN; mdl_delay 0 means never
   initial begin
      forever begin
         @(posedge user_clk_i);
         #1;
         mmcm_psdone_i = 1'b0;
         if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) mmcm_psdone_i = 1'b1;
         end
         if (mmcm_psen_o && mdl_delay > 0) mdl_cnt = mdl_delay;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse(input bit inc);
      phase_control_out = {6'($urandom), inc, 1'b1};
      drv_cyc = cyc;
      step();
      phase_control_out = 8'd0;
   endtask

   task automatic wait_done(input int start, input string tag);
      int n = 0;
      while (psdone_cnt == start && n < 600) begin
         step();
         n++;
      end
      if (psdone_cnt == start) check(tag, 0, 1);
   endtask

   // Predict the outcome of one request, queue it, issue it and wait for PSDONE
   task automatic send(input bit inc);
      bit   acc;
      exp_t e;
      int   d0;
      acc = m_locked && !(inc && m_pos == MAXS) && !(!inc && m_pos == -MAXS);
      if (acc) begin
         m_tmo = 1'b0;
         m_rej = 1'b0;
         m_ovr = 1'b0;
         if (mdl_delay > 0) m_pos += inc ? 1 : -1;
         else m_tmo = 1'b1;
      end else begin
         m_rej = 1'b1;
      end
      e = '{m_pos, m_tmo, m_rej, m_ovr};
      sb_q.push_back(e);
      d0 = psdone_cnt;
      pulse(inc);
      wait_done(d0, "psdone_timeout");
      step();
   endtask

   initial begin
      int p0, d0, c0;
      exp_t e;
      // Reset state
      step(3);
      check("rst_status", int'(phase_control_in), 0);
      check("rst_pos", int'(phase_pos_o), 0);
      check("rst_psen", int'(mmcm_psen_o), 0);
      rst_i = 1'b0;
      step(4);
      check("locked", int'(phase_control_in[6]), 1);
      check("idle_busy", int'(phase_control_in[1]), 0);

      // 1: single increment, PSDONE 12 cycles after PSEN
      mdl_delay = 12;
      p0 = psen_cnt;
      send(1'b1);
      check("t1_psen_count", psen_cnt - p0, 1);
      check("t1_psincdec", int'(psen_dir), 1);
      check("t1_psen_latency", psen_cyc - drv_cyc, 2);
      check("t1_psdone_latency", psdone_cyc - done_in_cyc, 1);
      check("t1_busy_after", int'(phase_control_in[1]), 0);

      // 2: run up to +MAX_STEPS, then one rejected step and a decrement
      mdl_delay = 1;
      while (m_pos < MAXS) send(1'b1);
      check("t2_at_max", int'(phase_control_in[2]), 1);
      p0 = psen_cnt;
      send(1'b1);
      check("t2_reject_no_psen", psen_cnt - p0, 0);
      check("t2_reject_latency", psdone_cyc - drv_cyc, 2);
      send(1'b0);
      check("t2_dec_dir", int'(psen_dir), 0);
      check("t2_dec_pos", int'($signed(phase_pos_o)), MAXS - 1);

      // 3: MMCM never answers
      mdl_delay = 0;
      send(1'b1);
      check("t3_timeout_latency", psdone_cyc - psen_cyc, TIMEOUT + 1);
      mdl_delay = 1;
      send(1'b0);
      check("t3_tmo_cleared", int'(phase_control_in[4]), 0);

      // 4: second PSEN during WAIT is an overrun
      mdl_delay = 12;
      m_pos += 1;
      m_tmo = 1'b0;
      m_rej = 1'b0;
      m_ovr = 1'b1;
      e = '{m_pos, m_tmo, m_rej, m_ovr};
      sb_q.push_back(e);
      p0 = psen_cnt;
      d0 = psdone_cnt;
      pulse(1'b1);
      step(2);
      pulse(1'b1);
      wait_done(d0, "t4_psdone_timeout");
      step(20);
      check("t4_psen_count", psen_cnt - p0, 1);
      check("t4_psdone_count", psdone_cnt - d0, 1);

      // 5: lose lock while waiting at pos +5
      rst_i = 1'b1;
      step(2);
      rst_i = 1'b0;
      m_pos = 0; m_tmo = 1'b0; m_rej = 1'b0; m_ovr = 1'b0;
      step(4);
      mdl_delay = 1;
      for (int i = 0; i < 5; i++) send(1'b1);
      check("t5_pos5", int'($signed(phase_pos_o)), 5);
      mdl_delay = 0;
      e = '{0, 1'b1, 1'b0, 1'b0};
      sb_q.push_back(e);
      d0 = psdone_cnt;
      pulse(1'b1);
      step(6);
      mmcm_locked_i = 1'b0;
      m_locked = 1'b0;
      m_pos = 0;
      m_tmo = 1'b1;
      step(3);
      check("t5_pos_zeroed", int'(phase_pos_o), 0);
      wait_done(d0, "t5_psdone_timeout");
      step();
      check("t5_locked_low", int'(phase_control_in[6]), 0);
      mdl_delay = 1;
      send(1'b1);
      mmcm_locked_i = 1'b1;
      m_locked = 1'b1;
      step(4);
      send(1'b1);

      // 6: asynchronous reset in WAIT
      mdl_delay = 0;
      pulse(1'b1);
      step(5);
      check("t6_busy_before", int'(phase_control_in[1]), 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("t6_async_status", int'(phase_control_in), 0);
      check("t6_async_pos", int'(phase_pos_o), 0);
      check("t6_async_psen", int'(mmcm_psen_o), 0);
      step(2);
      rst_i = 1'b0;
      c0 = psdone_cnt;
      step(TIMEOUT + 20);
      check("t6_no_psdone", psdone_cnt - c0, 0);
      check("t6_pos", int'(phase_pos_o), 0);
      check("t6_idle", int'(phase_control_in[1]), 0);
      check("sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
